// File: rtl/axil_wr_demux.sv
// ---------------------------------------------------------------------------
// axil_wr_demux
//   Write-channel router for the priority AXI-Lite interconnect. Steers the
//   arbitrated master's AW/W beats to the slave chosen by the upstream address
//   decoder and returns that slave's B response. A decode error is answered
//   locally with DECERR and never reaches a slave.
//
// Ports
//   aclk, aresetn        clock, synchronous active-low reset
//   slv_valid            registered one-hot (possibly multi-hot) slave select
//   slv_invalid          registered decode-error flag
//   m_axil_aw*/w*/b*     master-facing AW, W, B channels
//   s_axil_aw*/w*/b*     slave-facing channels, flattened, slave k in slice k
//
// State table
//   IDLE  | waiting for a decoded select or decode error
//   ROUTE | forwarding AW and W to slave r_sel until both have handshaken
//   ERR   | absorbing AW and W of an unmapped write
//   RESP  | forwarding B from slave r_sel
//   ERESP | returning DECERR to the master
// ---------------------------------------------------------------------------
module axil_wr_demux #(
   parameter int NUMBER_SLAVE   = 4,
   parameter int AXI_ADDR_WIDTH = 32,
   parameter int AXI_DATA_WIDTH = 32
) (
   input  logic                                      aclk,
   input  logic                                      aresetn,
   input  logic [NUMBER_SLAVE-1:0]                   slv_valid,
   input  logic                                      slv_invalid,
   input  logic [AXI_ADDR_WIDTH-1:0]                 m_axil_awaddr,
   input  logic                                      m_axil_awvalid,
   output logic                                      m_axil_awready,
   input  logic [AXI_DATA_WIDTH-1:0]                 m_axil_wdata,
   input  logic [AXI_DATA_WIDTH/8-1:0]               m_axil_wstrb,
   input  logic                                      m_axil_wvalid,
   output logic                                      m_axil_wready,
   output logic [1:0]                                m_axil_bresp,
   output logic                                      m_axil_bvalid,
   input  logic                                      m_axil_bready,
   output logic [NUMBER_SLAVE*AXI_ADDR_WIDTH-1:0]    s_axil_awaddr,
   output logic [NUMBER_SLAVE-1:0]                   s_axil_awvalid,
   input  logic [NUMBER_SLAVE-1:0]                   s_axil_awready,
   output logic [NUMBER_SLAVE*AXI_DATA_WIDTH-1:0]    s_axil_wdata,
   output logic [NUMBER_SLAVE*AXI_DATA_WIDTH/8-1:0]  s_axil_wstrb,
   output logic [NUMBER_SLAVE-1:0]                   s_axil_wvalid,
   input  logic [NUMBER_SLAVE-1:0]                   s_axil_wready,
   input  logic [NUMBER_SLAVE*2-1:0]                 s_axil_bresp,
   input  logic [NUMBER_SLAVE-1:0]                   s_axil_bvalid,
   output logic [NUMBER_SLAVE-1:0]                   s_axil_bready
);

   localparam int SW = (NUMBER_SLAVE > 1) ? $clog2(NUMBER_SLAVE) : 1;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ROUTE = 3'd1,
      ERR   = 3'd2,
      RESP  = 3'd3,
      ERESP = 3'd4
   } state_t;

   state_t        r_state;
   state_t        w_state_nxt;
   logic [SW-1:0] r_sel;
   logic [SW-1:0] w_sel_nxt;
   logic [SW-1:0] w_low_idx;
   logic          r_aw_done;
   logic          r_w_done;
   logic          w_aw_done_nxt;
   logic          w_w_done_nxt;
   logic          w_aw_hs;
   logic          w_w_hs;

   // Payload is broadcast; only the handshake signals are steered.
   assign s_axil_awaddr = {NUMBER_SLAVE{m_axil_awaddr}};
   assign s_axil_wdata  = {NUMBER_SLAVE{m_axil_wdata}};
   assign s_axil_wstrb  = {NUMBER_SLAVE{m_axil_wstrb}};

   // Overlapping decode ranges resolve to the lowest slave index.
   always_comb begin
      w_low_idx = '0;
      for (int k = NUMBER_SLAVE-1; k >= 0; k--) begin
         if (slv_valid[k]) w_low_idx = SW'(k);
      end
   end

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         r_state   <= IDLE;
         r_sel     <= '0;
         r_aw_done <= 1'b0;
         r_w_done  <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_sel     <= w_sel_nxt;
         r_aw_done <= w_aw_done_nxt;
         r_w_done  <= w_w_done_nxt;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_sel_nxt      = r_sel;
      w_aw_done_nxt  = r_aw_done;
      w_w_done_nxt   = r_w_done;
      w_aw_hs        = 1'b0;
      w_w_hs         = 1'b0;
      m_axil_awready = 1'b0;
      m_axil_wready  = 1'b0;
      m_axil_bvalid  = 1'b0;
      m_axil_bresp   = 2'b00;
      s_axil_awvalid = '0;
      s_axil_wvalid  = '0;
      s_axil_bready  = '0;

      case (r_state)
         IDLE: begin
            if (|slv_valid) begin
               w_sel_nxt     = w_low_idx;
               w_aw_done_nxt = 1'b0;
               w_w_done_nxt  = 1'b0;
               w_state_nxt   = ROUTE;
            end else if (slv_invalid) begin
               w_aw_done_nxt = 1'b0;
               w_w_done_nxt  = 1'b0;
               w_state_nxt   = ERR;
            end
         end

         ROUTE: begin
            s_axil_awvalid[r_sel] = m_axil_awvalid & ~r_aw_done;
            m_axil_awready        = s_axil_awready[r_sel] & ~r_aw_done;
            s_axil_wvalid[r_sel]  = m_axil_wvalid & ~r_w_done;
            m_axil_wready         = s_axil_wready[r_sel] & ~r_w_done;
            w_aw_hs = m_axil_awvalid & m_axil_awready;
            w_w_hs  = m_axil_wvalid & m_axil_wready;
            if (w_aw_hs) w_aw_done_nxt = 1'b1;
            if (w_w_hs)  w_w_done_nxt  = 1'b1;
            if ((r_aw_done | w_aw_hs) && (r_w_done | w_w_hs)) w_state_nxt = RESP;
         end

         ERR: begin
            m_axil_awready = m_axil_awvalid & ~r_aw_done;
            m_axil_wready  = m_axil_wvalid & ~r_w_done;
            w_aw_hs = m_axil_awready;
            w_w_hs  = m_axil_wready;
            if (w_aw_hs) w_aw_done_nxt = 1'b1;
            if (w_w_hs)  w_w_done_nxt  = 1'b1;
            if ((r_aw_done | w_aw_hs) && (r_w_done | w_w_hs)) w_state_nxt = ERESP;
         end

         RESP: begin
            m_axil_bvalid        = s_axil_bvalid[r_sel];
            m_axil_bresp         = s_axil_bresp[int'(r_sel)*2 +: 2];
            s_axil_bready[r_sel] = m_axil_bready;
            if (s_axil_bvalid[r_sel] && m_axil_bready) w_state_nxt = IDLE;
         end

         ERESP: begin
            m_axil_bvalid = 1'b1;
            m_axil_bresp  = 2'b11;
            if (m_axil_bready) w_state_nxt = IDLE;
         end

         default: w_state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_axil_wr_demux.sv
module tb_axil_wr_demux;

   localparam int NS = 4;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int SB = DW/8;

   logic              aclk = 1'b0;
   logic              aresetn;
   logic [NS-1:0]     slv_valid;
   logic              slv_invalid;
   logic [AW-1:0]     m_awaddr;
   logic              m_awvalid;
   logic              m_awready;
   logic [DW-1:0]     m_wdata;
   logic [SB-1:0]     m_wstrb;
   logic              m_wvalid;
   logic              m_wready;
   logic [1:0]        m_bresp;
   logic              m_bvalid;
   logic              m_bready;
   logic [NS*AW-1:0]  s_awaddr;
   logic [NS-1:0]     s_awvalid;
   logic [NS-1:0]     s_awready;
   logic [NS*DW-1:0]  s_wdata;
   logic [NS*SB-1:0]  s_wstrb;
   logic [NS-1:0]     s_wvalid;
   logic [NS-1:0]     s_wready;
   logic [NS*2-1:0]   s_bresp;
   logic [NS-1:0]     s_bvalid;
   logic [NS-1:0]     s_bready;

   int checks = 0;
   int errors = 0;
   logic [1:0] sb_q[$];

   always #5 aclk = ~aclk;

   axil_wr_demux #(
      .NUMBER_SLAVE  (NS),
      .AXI_ADDR_WIDTH(AW),
      .AXI_DATA_WIDTH(DW)
   ) dut (
      .aclk          (aclk),
      .aresetn       (aresetn),
      .slv_valid     (slv_valid),
      .slv_invalid   (slv_invalid),
      .m_axil_awaddr (m_awaddr),
      .m_axil_awvalid(m_awvalid),
      .m_axil_awready(m_awready),
      .m_axil_wdata  (m_wdata),
      .m_axil_wstrb  (m_wstrb),
      .m_axil_wvalid (m_wvalid),
      .m_axil_wready (m_wready),
      .m_axil_bresp  (m_bresp),
      .m_axil_bvalid (m_bvalid),
      .m_axil_bready (m_bready),
      .s_axil_awaddr (s_awaddr),
      .s_axil_awvalid(s_awvalid),
      .s_axil_awready(s_awready),
      .s_axil_wdata  (s_wdata),
      .s_axil_wstrb  (s_wstrb),
      .s_axil_wvalid (s_wvalid),
      .s_axil_wready (s_wready),
      .s_axil_bresp  (s_bresp),
      .s_axil_bvalid (s_bvalid),
      .s_axil_bready (s_bready)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic idle_inputs();
      m_awvalid   = 1'b0;
      m_wvalid    = 1'b0;
      m_bready    = 1'b0;
      slv_valid   = '0;
      slv_invalid = 1'b0;
      s_awready   = '0;
      s_wready    = '0;
      s_bvalid    = '0;
      s_bresp     = '0;
   endtask

   function automatic logic [63:0] all_hs();
      return {45'd0, s_awvalid, s_wvalid, s_bready, m_awready, m_wready, m_bvalid, m_bresp};
   endfunction

   // One write: exp_idx < 0 means decode error. aw_dly/w_dly are the cycles
   // after ROUTE entry at which the slave raises awready/wready; b_dly is the
   // number of cycles the master holds bready low after bvalid appears.
   task automatic run_txn(input string tag, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                          input logic [SB-1:0] strb, input logic [NS-1:0] sel, input logic inv,
                          input int exp_idx, input logic [1:0] sresp,
                          input int aw_dly, input int w_dly, input int b_dly);
      logic [NS-1:0] oh;
      logic          routed;
      logic          aw_seen, w_seen, slv_aw, slv_w, b_done;
      int            bv_cnt, bv_at;
      routed = (exp_idx >= 0);
      oh = '0;
      if (routed) oh[exp_idx] = 1'b1;
      bv_at = ((aw_dly > w_dly) ? aw_dly : w_dly) + 1;
      sb_q.push_back(routed ? sresp : 2'b11);

      @(posedge aclk); #1;
      m_awaddr  = addr;
      m_wdata   = data;
      m_wstrb   = strb;
      m_awvalid = 1'b1;
      m_wvalid  = 1'b1;
      @(posedge aclk); #1;
      slv_valid   = sel;
      slv_invalid = inv;

      aw_seen = 1'b0; w_seen = 1'b0; slv_aw = 1'b0; slv_w = 1'b0;
      b_done = 1'b0; bv_cnt = 0;
      for (int i = 0; i < 40 && !b_done; i++) begin
         @(posedge aclk); #1;
         if (aw_seen) m_awvalid = 1'b0;
         if (w_seen)  m_wvalid  = 1'b0;
         s_awready = (i >= aw_dly) ? '1 : '0;
         s_wready  = (i >= w_dly)  ? '1 : '0;
         s_bvalid  = ~oh;
         if (slv_aw && slv_w) s_bvalid = s_bvalid | oh;
         for (int k = 0; k < NS; k++) s_bresp[k*2 +: 2] = oh[k] ? sresp : 2'b01;
         m_bready = (bv_cnt >= b_dly);

         @(negedge aclk);
         chk($sformatf("%s_s_awvalid_c%0d", tag, i), 64'(s_awvalid), 64'((routed && !aw_seen) ? oh : '0));
         chk($sformatf("%s_s_wvalid_c%0d", tag, i),  64'(s_wvalid),  64'((routed && !w_seen)  ? oh : '0));
         chk($sformatf("%s_m_awready_c%0d", tag, i), 64'(m_awready),
             64'((routed ? (i >= aw_dly) : 1'b1) && !aw_seen));
         chk($sformatf("%s_m_wready_c%0d", tag, i),  64'(m_wready),
             64'((routed ? (i >= w_dly) : 1'b1) && !w_seen));
         chk($sformatf("%s_m_bvalid_c%0d", tag, i),  64'(m_bvalid), 64'(i >= bv_at));
         if (i == 0) begin
            for (int k = 0; k < NS; k++) begin
               chk($sformatf("%s_awaddr_bcast%0d", tag, k), 64'(s_awaddr[k*AW +: AW]), 64'(addr));
               chk($sformatf("%s_wdata_bcast%0d", tag, k),  64'(s_wdata[k*DW +: DW]),  64'(data));
               chk($sformatf("%s_wstrb_bcast%0d", tag, k),  64'(s_wstrb[k*SB +: SB]),  64'(strb));
            end
         end
         if (m_bvalid) begin
            chk($sformatf("%s_bresp_hold_c%0d", tag, i), 64'(m_bresp), 64'(sb_q[0]));
            chk($sformatf("%s_s_bready_c%0d", tag, i), 64'(s_bready),
                64'((routed && m_bready) ? oh : '0));
            bv_cnt++;
            if (m_bready) begin
               chk($sformatf("%s_bresp_sb", tag), 64'(m_bresp), 64'(sb_q.pop_front()));
               b_done = 1'b1;
            end
         end else begin
            chk($sformatf("%s_s_bready_idle_c%0d", tag, i), 64'(s_bready), 64'(0));
         end
         if (m_awvalid && m_awready) aw_seen = 1'b1;
         if (m_wvalid && m_wready)   w_seen  = 1'b1;
         if (|(s_awvalid & s_awready)) slv_aw = 1'b1;
         if (|(s_wvalid & s_wready))   slv_w  = 1'b1;
      end

      checks++;
      assert (b_done) else begin
         errors++;
         $error("FAIL %s_timeout observed=no_b_handshake expected=b_handshake", tag);
      end
      if (!b_done && sb_q.size() != 0) void'(sb_q.pop_front());

      @(posedge aclk); #1;
      idle_inputs();
      @(negedge aclk);
      chk($sformatf("%s_idle_after", tag), all_hs(), 64'(0));
   endtask

   initial begin
      aresetn  = 1'b0;
      m_awaddr = '0;
      m_wdata  = '0;
      m_wstrb  = '0;
      idle_inputs();
      // Inputs active during reset must not leak through.
      m_awvalid = 1'b1;
      m_wvalid  = 1'b1;
      slv_valid = 4'b0001;
      s_awready = '1;
      s_wready  = '1;
      s_bvalid  = '1;
      for (int i = 0; i < 3; i++) begin
         @(posedge aclk); #1;
         @(negedge aclk);
         chk($sformatf("reset_outputs_c%0d", i), all_hs(), 64'(0));
      end
      @(posedge aclk); #1;
      idle_inputs();
      aresetn = 1'b1;
      @(posedge aclk); #1;

      run_txn("s1_basic", 32'h0000_1004, 32'hA5A5_0001, 4'hF, 4'b0010, 1'b0, 1, 2'b00, 0, 0, 0);
      run_txn("s2_wlate", 32'h0000_2008, 32'h1234_5678, 4'h3, 4'b0100, 1'b0, 2, 2'b00, 0, 3, 0);
      run_txn("decerr",   32'hDEAD_0000, 32'h0BAD_F00D, 4'hF, 4'b0000, 1'b1, -1, 2'b00, 0, 0, 4);
      run_txn("multihot", 32'h0000_100C, 32'hCAFE_0002, 4'hC, 4'b0110, 1'b0, 1, 2'b10, 0, 0, 0);
      run_txn("s0_bhold", 32'h0000_0010, 32'h0000_0F0F, 4'h1, 4'b0001, 1'b0, 0, 2'b00, 0, 0, 5);
      run_txn("valid_wins", 32'h0000_1100, 32'h7777_8888, 4'hF, 4'b1000, 1'b1, 3, 2'b10, 2, 1, 0);

      // Reset while in ROUTE with only AW done.
      @(posedge aclk); #1;
      m_awaddr  = 32'h0000_2000;
      m_wdata   = 32'h5555_AAAA;
      m_wstrb   = 4'hF;
      m_awvalid = 1'b1;
      m_wvalid  = 1'b1;
      @(posedge aclk); #1;
      slv_valid = 4'b0100;
      s_awready = '1;
      s_wready  = '0;
      @(posedge aclk); #1;
      @(negedge aclk);
      chk("rst_mid_aw_hs", 64'({m_awready, s_awvalid}), 64'({1'b1, 4'b0100}));
      chk("rst_mid_w_pending", 64'({m_wready, s_wvalid}), 64'({1'b0, 4'b0100}));
      @(posedge aclk); #1;
      m_awvalid = 1'b0;
      aresetn   = 1'b0;
      @(posedge aclk); #1;
      @(negedge aclk);
      chk("rst_mid_outputs", all_hs(), 64'(0));
      @(posedge aclk); #1;
      idle_inputs();
      aresetn = 1'b1;
      @(posedge aclk); #1;
      @(negedge aclk);
      chk("rst_mid_no_resume", all_hs(), 64'(0));

      run_txn("s3_after_rst", 32'h0000_3000, 32'h3333_3333, 4'hF, 4'b1000, 1'b0, 3, 2'b00, 0, 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
